// File: rtl/adsr_env_gen_if.sv
// Gate, envelope settings and envelope outputs of one ADSR voice.
// The gate is a plain level: there is no valid/ready handshake on this bus.
interface adsr_env_gen_if #(
    parameter int WIDTH = 8
);
    logic             trig;
    logic             retrig_en;
    logic [WIDTH-1:0] adsr_ai;
    logic [WIDTH-1:0] adsr_di;
    logic [WIDTH-1:0] adsr_s;
    logic [WIDTH-1:0] adsr_ri;
    logic [WIDTH-1:0] level;
    logic [2:0]       phase;
    logic             busy;
    logic             done;

    modport master (
        output trig, retrig_en, adsr_ai, adsr_di, adsr_s, adsr_ri,
        input  level, phase, busy, done
    );

    modport slave (
        input  trig, retrig_en, adsr_ai, adsr_di, adsr_s, adsr_ri,
        output level, phase, busy, done
    );
endinterface

// File: rtl/adsr_env_gen.sv
// ADSR envelope generator: synchronised gate, prescaled step tick, saturating
// level arithmetic and a phase FSM that is exposed directly as the phase output.
module adsr_env_gen #(
    parameter int WIDTH    = 8,
    parameter int TICK_DIV = 2500
) (
    input logic          clk,
    input logic          rst,
    adsr_env_gen_if.slave env
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } phase_e;

    localparam int               CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [WIDTH-1:0] FS = '1;

    logic          trig_m_q, trig_s_q, trig_d_q;
    logic          rise, fall;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick;

    phase_e           phase_q;
    logic [WIDTH-1:0] level_q;
    logic             done_q;

    logic [WIDTH:0]   att_sum, dec_diff, rel_diff;
    logic [WIDTH-1:0] att_new, dec_new, rel_new;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            trig_m_q <= 1'b0;
            trig_s_q <= 1'b0;
            trig_d_q <= 1'b0;
        end else begin
            trig_m_q <= env.trig;
            trig_s_q <= trig_m_q;
            trig_d_q <= trig_s_q;
        end
    end

    assign rise = trig_s_q & ~trig_d_q;
    assign fall = ~trig_s_q & trig_d_q;

    // With TICK_DIV=1 the counter sits at 0 and tick stays high every cycle.
    assign tick  = (cnt_q == CW'(TICK_DIV - 1));
    assign cnt_d = tick ? '0 : cnt_q + CW'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    // Next levels are formed one bit wider so overflow/underflow is visible.
    always_comb begin
        att_sum  = {1'b0, level_q} + {1'b0, env.adsr_ai};
        dec_diff = {1'b0, level_q} - {1'b0, env.adsr_di};
        rel_diff = {1'b0, level_q} - {1'b0, env.adsr_ri};

        att_new = att_sum[WIDTH-1:0];
        if (env.adsr_ai == '0 || att_sum > {1'b0, FS}) att_new = FS;

        dec_new = dec_diff[WIDTH-1:0];
        if (env.adsr_di == '0 || env.adsr_s >= level_q || dec_diff[WIDTH] ||
            dec_diff[WIDTH-1:0] < env.adsr_s)
            dec_new = env.adsr_s;

        rel_new = rel_diff[WIDTH-1:0];
        if (env.adsr_ri == '0 || rel_diff[WIDTH]) rel_new = '0;
    end

    // A tick landing on a phase-change edge still uses the old phase's rule.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q <= IDLE;
            level_q <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (phase_q)
                IDLE: begin
                    level_q <= '0;
                    if (rise) phase_q <= ATTACK;
                end
                ATTACK: begin
                    if (tick) begin
                        level_q <= att_new;
                        if (att_new == FS) phase_q <= DECAY;
                    end
                    if (fall) phase_q <= RELEASE;
                end
                DECAY: begin
                    if (tick) begin
                        level_q <= dec_new;
                        if (dec_new == env.adsr_s) phase_q <= SUSTAIN;
                    end
                    if (fall) phase_q <= RELEASE;
                end
                SUSTAIN: begin
                    if (tick) level_q <= env.adsr_s;
                    if (fall) phase_q <= RELEASE;
                end
                RELEASE: begin
                    if (tick) level_q <= rel_new;
                    if (rise) begin
                        phase_q <= ATTACK;
                        if (!env.retrig_en) level_q <= '0;
                    end else if (tick && rel_new == '0) begin
                        phase_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    phase_q <= IDLE;
                    level_q <= '0;
                end
            endcase
        end
    end

    assign env.level = level_q;
    assign env.phase = phase_q;
    assign env.busy  = (phase_q != IDLE);
    assign env.done  = done_q;
endmodule

// File: tb/tb_adsr_env_gen.sv
// Bench for adsr_env_gen (WIDTH=8, TICK_DIV=4): expected {phase, level} steps
// are queued with the stimulus and compared as each level step appears.
module tb_adsr_env_gen;
    localparam int W = 8;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    bit   ok;
    int   n;
    int   done_cnt;
    logic [W+2:0] exp;
    logic [W+2:0] exp_q[$];

    adsr_env_gen_if #(.WIDTH(W)) bus ();

    adsr_env_gen #(.WIDTH(W), .TICK_DIV(4)) dut (
        .clk (clk),
        .rst (rst),
        .env (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic push(input logic [2:0] p, input logic [W-1:0] l);
        exp_q.push_back({p, l});
    endtask

    // Waits (bounded) for the next level step; ok=0 on timeout.
    task automatic next_step(output bit got);
        logic [W-1:0] prev;
        prev = bus.level;
        got  = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (bus.level !== prev) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic cfg(input logic [W-1:0] ai, di, s, ri, input logic re);
        bus.adsr_ai   = ai;
        bus.adsr_di   = di;
        bus.adsr_s    = s;
        bus.adsr_ri   = ri;
        bus.retrig_en = re;
    endtask

    task automatic do_reset();
        rst      = 1'b0;
        bus.trig = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst      = 1'b0;
        bus.trig = 1'b0;
        cfg(8'd64, 8'd16, 8'd128, 8'd32, 1'b1);
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.level, bus.phase, bus.busy, bus.done} !== {8'd0, 3'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got level=%0d phase=%0d busy=%0b done=%0b, expected 0 0 0 0",
                     bus.level, bus.phase, bus.busy, bus.done);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        do_reset();
        cfg(8'd64, 8'd16, 8'd128, 8'd32, 1'b1);
        bus.trig = 1'b1;
        @(posedge clk); @(posedge clk); @(negedge clk);
        checks++;
        if (bus.phase !== 3'd0) begin
            errors++;
            $display("FAIL trig_latency_early: got phase=%0d, expected 0", bus.phase);
        end
        @(posedge clk); @(negedge clk);
        checks++;
        if ({bus.phase, bus.level} !== {3'd1, 8'd0}) begin
            errors++;
            $display("FAIL trig_latency: got phase=%0d level=%0d, expected phase=1 level=0", bus.phase, bus.level);
        end
        push(1, 64); push(1, 128); push(1, 192); push(2, 255);
        for (int v = 239; v > 128; v -= 16) push(2, W'(v));
        push(3, 128);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            next_step(ok);
            exp = exp_q.pop_front();
            checks++;
            if (!ok || {bus.phase, bus.level} !== exp) begin
                errors++;
                $display("FAIL basic_ad step%0d: got phase=%0d level=%0d (seen=%0b), expected phase=%0d level=%0d",
                         i, bus.phase, bus.level, ok, exp[W+2:W], exp[W-1:0]);
            end
        end
        repeat (12) @(negedge clk);
        checks++;
        if ({bus.phase, bus.level, bus.busy} !== {3'd3, 8'd128, 1'b1}) begin
            errors++;
            $display("FAIL basic_sustain_hold: got phase=%0d level=%0d busy=%0b, expected 3 128 1",
                     bus.phase, bus.level, bus.busy);
        end
        bus.trig = 1'b0;
        push(4, 96); push(4, 64); push(4, 32); push(0, 0);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            next_step(ok);
            exp = exp_q.pop_front();
            checks++;
            if (!ok || {bus.phase, bus.level} !== exp) begin
                errors++;
                $display("FAIL basic_release step%0d: got phase=%0d level=%0d (seen=%0b), expected phase=%0d level=%0d",
                         i, bus.phase, bus.level, ok, exp[W+2:W], exp[W-1:0]);
            end
        end
        checks++;
        if ({bus.done, bus.busy} !== 2'b10) begin
            errors++;
            $display("FAIL basic_done: got done=%0b busy=%0b, expected done=1 busy=0", bus.done, bus.busy);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_width: got done=%0b, expected 0", bus.done);
        end
    endtask

    task automatic test_zero_increments();
        do_reset();
        cfg(8'd0, 8'd0, 8'd100, 8'd0, 1'b1);
        bus.trig = 1'b1;
        push(2, 255); push(3, 100);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            next_step(ok);
            exp = exp_q.pop_front();
            checks++;
            if (!ok || {bus.phase, bus.level} !== exp) begin
                errors++;
                $display("FAIL zero_attack step%0d: got phase=%0d level=%0d (seen=%0b), expected phase=%0d level=%0d",
                         i, bus.phase, bus.level, ok, exp[W+2:W], exp[W-1:0]);
            end
        end
        repeat (8) @(negedge clk);
        bus.trig = 1'b0;
        push(0, 0);
        next_step(ok);
        exp = exp_q.pop_front();
        checks++;
        if (!ok || {bus.phase, bus.level, bus.done} !== {exp, 1'b1}) begin
            errors++;
            $display("FAIL zero_release: got phase=%0d level=%0d done=%0b (seen=%0b), expected phase=0 level=0 done=1",
                     bus.phase, bus.level, bus.done, ok);
        end
    endtask

    task automatic test_retrigger(input logic mode);
        do_reset();
        cfg(8'd40, 8'd16, 8'd128, 8'd8, mode);
        bus.trig = 1'b1;
        for (int v = 40; v <= 200; v += 40) push(1, W'(v));
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            next_step(ok);
            exp = exp_q.pop_front();
            checks++;
            if (!ok || {bus.phase, bus.level} !== exp) begin
                errors++;
                $display("FAIL retrig%0b_attack step%0d: got phase=%0d level=%0d (seen=%0b), expected phase=%0d level=%0d",
                         mode, i, bus.phase, bus.level, ok, exp[W+2:W], exp[W-1:0]);
            end
        end
        bus.trig    = 1'b0;
        bus.adsr_ai = 8'd64;
        for (int v = 192; v >= 160; v -= 8) push(4, W'(v));
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            next_step(ok);
            exp = exp_q.pop_front();
            checks++;
            if (!ok || {bus.phase, bus.level} !== exp) begin
                errors++;
                $display("FAIL retrig%0b_release step%0d: got phase=%0d level=%0d (seen=%0b), expected phase=%0d level=%0d",
                         mode, i, bus.phase, bus.level, ok, exp[W+2:W], exp[W-1:0]);
            end
        end
        bus.trig = 1'b1;
        if (mode) begin
            push(1, 224); push(2, 255);
        end else begin
            push(1, 0); push(1, 64);
        end
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            next_step(ok);
            exp = exp_q.pop_front();
            checks++;
            if (!ok || {bus.phase, bus.level} !== exp) begin
                errors++;
                $display("FAIL retrig%0b_resume step%0d: got phase=%0d level=%0d (seen=%0b), expected phase=%0d level=%0d",
                         mode, i, bus.phase, bus.level, ok, exp[W+2:W], exp[W-1:0]);
            end
        end
    endtask

    task automatic test_release_in_attack();
        do_reset();
        cfg(8'd64, 8'd16, 8'd128, 8'd32, 1'b1);
        bus.trig = 1'b1;
        push(1, 64); push(1, 128);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            next_step(ok);
            exp = exp_q.pop_front();
            checks++;
            if (!ok || {bus.phase, bus.level} !== exp) begin
                errors++;
                $display("FAIL rel_attack_rise step%0d: got phase=%0d level=%0d (seen=%0b), expected phase=%0d level=%0d",
                         i, bus.phase, bus.level, ok, exp[W+2:W], exp[W-1:0]);
            end
        end
        bus.trig = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.phase, bus.level} !== {3'd4, 8'd128}) begin
            errors++;
            $display("FAIL rel_attack_hold: got phase=%0d level=%0d, expected phase=4 level=128", bus.phase, bus.level);
        end
        push(4, 96); push(4, 64); push(4, 32); push(0, 0);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            next_step(ok);
            exp = exp_q.pop_front();
            checks++;
            if (!ok || {bus.phase, bus.level} !== exp) begin
                errors++;
                $display("FAIL rel_attack_fall step%0d: got phase=%0d level=%0d (seen=%0b), expected phase=%0d level=%0d",
                         i, bus.phase, bus.level, ok, exp[W+2:W], exp[W-1:0]);
            end
        end
        checks++;
        if (bus.done !== 1'b1) begin
            errors++;
            $display("FAIL rel_attack_done: got done=%0b, expected 1", bus.done);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        cfg(8'd64, 8'd16, 8'd128, 8'd32, 1'b1);
        bus.trig = 1'b1;
        push(1, 64); push(1, 128); push(1, 192); push(2, 255); push(2, 239);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            next_step(ok);
            exp = exp_q.pop_front();
            checks++;
            if (!ok || {bus.phase, bus.level} !== exp) begin
                errors++;
                $display("FAIL areset_pre step%0d: got phase=%0d level=%0d (seen=%0b), expected phase=%0d level=%0d",
                         i, bus.phase, bus.level, ok, exp[W+2:W], exp[W-1:0]);
            end
        end
        #2;
        rst      = 1'b0;
        bus.trig = 1'b0;
        #1;
        checks++;
        if ({bus.level, bus.phase, bus.busy, bus.done} !== {8'd0, 3'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL areset_immediate: got level=%0d phase=%0d busy=%0b done=%0b, expected 0 0 0 0",
                     bus.level, bus.phase, bus.busy, bus.done);
        end
        @(negedge clk);
        rst      = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) done_cnt++;
        end
        checks++;
        if ({bus.phase, bus.level, 32'(done_cnt)} !== {3'd0, 8'd0, 32'd0}) begin
            errors++;
            $display("FAIL areset_idle: got phase=%0d level=%0d done_pulses=%0d, expected 0 0 0",
                     bus.phase, bus.level, done_cnt);
        end
        bus.trig = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.phase !== 3'd1) begin
            errors++;
            $display("FAIL areset_restart: got phase=%0d, expected 1", bus.phase);
        end
    endtask

    task automatic test_sustain_saturation();
        do_reset();
        cfg(8'd64, 8'd0, 8'd128, 8'd0, 1'b1);
        bus.trig = 1'b1;
        push(1, 64); push(1, 128); push(1, 192); push(2, 255); push(3, 128);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            next_step(ok);
            exp = exp_q.pop_front();
            checks++;
            if (!ok || {bus.phase, bus.level} !== exp) begin
                errors++;
                $display("FAIL sat_pre step%0d: got phase=%0d level=%0d (seen=%0b), expected phase=%0d level=%0d",
                         i, bus.phase, bus.level, ok, exp[W+2:W], exp[W-1:0]);
            end
        end
        bus.adsr_s = 8'd250;
        repeat (4) @(negedge clk);
        checks++;
        if ({bus.phase, bus.level} !== {3'd3, 8'd250}) begin
            errors++;
            $display("FAIL sat_track: got phase=%0d level=%0d, expected phase=3 level=250", bus.phase, bus.level);
        end
        bus.trig = 1'b0;
        push(0, 0);
        next_step(ok);
        exp = exp_q.pop_front();
        checks++;
        if (!ok || {bus.phase, bus.level} !== exp) begin
            errors++;
            $display("FAIL sat_release: got phase=%0d level=%0d (seen=%0b), expected phase=0 level=0",
                     bus.phase, bus.level, ok);
        end
        bus.adsr_s  = 8'd255;
        bus.adsr_ai = 8'd200;
        bus.trig    = 1'b1;
        push(1, 200); push(2, 255);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            next_step(ok);
            exp = exp_q.pop_front();
            checks++;
            if (!ok || {bus.phase, bus.level} !== exp) begin
                errors++;
                $display("FAIL sat_attack step%0d: got phase=%0d level=%0d (seen=%0b), expected phase=%0d level=%0d",
                         i, bus.phase, bus.level, ok, exp[W+2:W], exp[W-1:0]);
            end
        end
        repeat (8) @(negedge clk);
        checks++;
        if ({bus.phase, bus.level} !== {3'd3, 8'd255}) begin
            errors++;
            $display("FAIL sat_decay_fs: got phase=%0d level=%0d, expected phase=3 level=255", bus.phase, bus.level);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_basic();
        test_zero_increments();
        test_retrigger(1'b1);
        test_retrigger(1'b0);
        test_release_in_attack();
        test_async_reset();
        test_sustain_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
